serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Parametrised bit-serial adder/subtractor; successor to the single-bit-per-clock serial adder.
//  Accepts two WIDTH-bit parallel operands on a start strobe.
//  Processes them LSB-first, one bit per clock, through a single full-adder cell.
//  Streams each result bit out, then presents the parallel sum, carry and overflow with a done pulse.
//  Sits between a control FSM/CPU datapath and any consumer wanting area-cheap arithmetic.
// PARAMETERS
//  WIDTH   8   operand/result width in bits, >= 2
//  CNT_W   $clog2(WIDTH)+1   bit counter width (localparam, derived; not overridable)
// PORTS
//  clk     in   1      single clock, rising-edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      load request; honoured only when busy==0
//  a_in    in   WIDTH  operand A, sampled on accepted start
//  b_in    in   WIDTH  operand B, sampled on accepted start
//  c_in    in   1      carry-in (add) / borrow-in (sub), sampled on accepted start
//  sub     in   1      0: A+B+c_in, 1: A-B-c_in; sampled on accepted start
//  busy    out  1      high while in RUN
//  s_out   out  1      current serial result bit (LSB first); valid when s_valid
//  s_valid out  1      high for exactly WIDTH consecutive cycles per operation
//  sum     out  WIDTH  parallel result; valid from done, held until next accepted start
//  c_out   out  1      final carry; in sub mode 1 = no borrow, 0 = borrow
//  ovf     out  1      signed (two's complement) overflow = carry into MSB ^ carry out of MSB
//  done    out  1      one-cycle pulse, first cycle the result is valid
// BEHAVIOUR
//  - Reset (rst=1 at an edge) overrides everything, including mid-operation.
//    State->IDLE; busy,s_valid,s_out,done,c_out,ovf=0; sum=0; shift regs and counter cleared.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE --start--> RUN.  RUN --(cnt==WIDTH-1)--> DONE.
//    DONE --start--> RUN; DONE --!start--> IDLE.
//  - Accepted start (IDLE or DONE): load A into areg and B into breg, both unmodified.
//    cy = sub ? ~c_in : c_in. Clear cnt. Latch sub.
//  - Inversion of B in sub mode is done on the live bit each cycle, not at load time.
//  - RUN, each cycle: bit b' = breg[0]^sub.
//    s_out = areg[0]^b'^cy (combinational from regs); s_valid=1.
//    At the edge: cy<=maj(areg[0],b',cy).
//    Shift s_out into result reg MSB-side and shift areg/breg right. cnt++.
//  - On the last RUN edge, register the parallel outputs:
//    sum<=final result; c_out<=final carry; ovf<=cin_msb^cout_msb; done<=1 for one cycle (DONE).
//  - Latency: start accepted at edge E; s_valid high in cycles E+1..E+WIDTH.
//    done high in cycle E+WIDTH+1. Throughput: one op per WIDTH+1 cycles with back-to-back starts.
//  - start while busy: ignored, no side effect; the operands in flight are unchanged.
//  - sum/c_out/ovf are held stable from done until the next accepted start.
//    They then retain their old values until the new done; they are not cleared at start.
//  - All arithmetic is modulo 2^WIDTH; no saturation.
// STRUCTURE
//  - serial_arith_pkg: state enum (ST_IDLE/ST_RUN/ST_DONE, 2-bit), MODE_ADD=1'b0/MODE_SUB=1'b1.
//  - Sub-module fa_cell: 1-bit full adder (a,b,ci -> s,co), instantiated once.
//  - Top: FSM, cnt, areg/breg/res shift regs, cy/cy_msb flops.
// TESTING
//  - WIDTH=4: a=1101,b=1001,c_in=0,sub=0 -> s_out stream 0,1,1,0. sum=0110, c_out=1, ovf=1, done at E+5.
//  - WIDTH=4: a=1011,b=1001,c_in=1,sub=0 -> sum=0101, c_out=1, ovf=1.
//  - WIDTH=8: 0x05-0x07, sub=1, c_in=0 -> sum=0xFE, c_out=0 (borrow), ovf=0.
//    Also 0x7F+0x01 add -> sum=0x80, c_out=0, ovf=1.
//  - WIDTH=8: start op; pulse start again at E+3 -> ignored, result unchanged.
//    Start asserted in the DONE cycle -> new op runs, s_valid at E+WIDTH+2.
//  - rst at E+3 mid-op -> next cycle all outputs 0, state IDLE.
//    A fresh start then gives the correct result with no residue.
//  - Random sweep, WIDTH=8, 1000 ops, both modes: sum/c_out/ovf match the reference model.
//    s_valid count == WIDTH per op.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial add/subtract datapath.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Subtraction is A + ~B + ~borrowIn, so the carry seed is the inverted borrow.
  function automatic logic initCarry(input logic carryIn, input logic mode);
    return (mode == MODE_SUB) ? ~carryIn : carryIn;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single-bit full adder; the only arithmetic cell of the serial datapath.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  // Sum is the parity of the three inputs, carry is their majority.
  always_comb begin
    s_o  = a_i ^ b_i ^ ci_i;
    co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: operands enter in parallel, are consumed
// LSB-first through one full adder, and the result leaves both as a bit
// stream and as a held parallel word with carry and signed overflow.
module serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             s_out,
  output logic             s_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic bLive;
  logic faSum;
  logic faCarry;
  logic loadOp;
  logic lastBit;

  assign bLive = breg_q[0] ^ sub_q;

  fa_cell u_fa (
    .a_i (areg_q[0]),
    .b_i (bLive),
    .ci_i(cy_q),
    .s_o (faSum),
    .co_o(faCarry)
  );

  // Next-state logic: sequencing, serial shifting, and result capture on the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    areg_d  = areg_q;
    breg_d  = breg_q;
    res_d   = res_q;
    cy_d    = cy_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    loadOp  = start && (state_q != ST_RUN);
    lastBit = (state_q == ST_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        areg_d = areg_q >> 1;
        breg_d = breg_q >> 1;
        res_d  = (res_q >> 1) | ((WIDTH-1)'(faSum) << (WIDTH - 2));
        cy_d   = faCarry;
        cnt_d  = cnt_q + CNT_W'(1);
        if (lastBit) begin
          state_d = ST_DONE;
          sum_d   = {faSum, res_q};
          cout_d  = faCarry;
          ovf_d   = cy_q ^ faCarry;
        end
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (loadOp) begin
      areg_d = a_in;
      breg_d = b_in;
      res_d  = '0;
      cy_d   = initCarry(c_in, sub);
      cnt_d  = '0;
      sub_d  = sub;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      areg_q  <= '0;
      breg_q  <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      sub_q   <= MODE_ADD;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      areg_q  <= areg_d;
      breg_q  <= breg_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status and stream outputs decode directly from the registered state.
  always_comb begin
    busy    = (state_q == ST_RUN);
    s_valid = busy;
    s_out   = busy & faSum;
    done    = (state_q == ST_DONE);
    sum     = sum_q;
    c_out   = cout_q;
    ovf     = ovf_q;
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed 4-bit vectors with literal expectations,
// and an 8-bit instance checked every cycle against an arithmetic model.
module tb_serial_addsub;

  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;

  logic       start4, cin4, sub4;
  logic [3:0] a4, b4;
  logic       busy4, sOut4, sValid4, cout4, ovf4, done4;
  logic [3:0] sum4;

  logic          start8, cin8, sub8;
  logic [W8-1:0] a8, b8;
  logic          busy8, sOut8, sValid8, cout8, ovf8, done8;
  logic [W8-1:0] sum8;

  int total = 0;
  int bad   = 0;

  // Model state for the 8-bit instance
  bit            modelOn = 1'b0;
  int            mRunLeft = 0;
  logic [W8-1:0] pSum, mSum;
  logic          pCout, pOvf, mCout, mOvf, mDone;
  int            sValCnt = 0;

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .c_in(cin4), .sub(sub4),
    .busy(busy4), .s_out(sOut4), .s_valid(sValid4), .sum(sum4), .c_out(cout4),
    .ovf(ovf4), .done(done4)
  );

  serial_addsub #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .c_in(cin8), .sub(sub8),
    .busy(busy8), .s_out(sOut8), .s_valid(sValid8), .sum(sum8), .c_out(cout8),
    .ovf(ovf8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: unsigned result/carry and signed overflow from integers.
  function automatic void calc(input logic [7:0] a, input logic [7:0] b, input logic c,
                               input logic s, output logic [7:0] r, output logic co,
                               output logic ov);
    int ua, ub, ci, sa, sb, u, sr;
    ua = int'(a);
    ub = int'(b);
    ci = c ? 1 : 0;
    sa = a[7] ? ua - 256 : ua;
    sb = b[7] ? ub - 256 : ub;
    if (!s) begin
      u  = ua + ub + ci;
      co = (u > 255);
      sr = sa + sb + ci;
    end else begin
      u  = ua - ub - ci;
      co = (u >= 0);
      sr = sa - sb - ci;
    end
    r  = u[7:0];
    ov = (sr > 127) || (sr < -128);
  endfunction

  // Model timeline: an accepted start yields W8 stream cycles then one done cycle.
  always @(posedge clk) begin
    if (rst) begin
      modelOn  = 1'b1;
      mRunLeft = 0;
      mSum     = '0;
      mCout    = 1'b0;
      mOvf     = 1'b0;
      mDone    = 1'b0;
      pSum     = '0;
    end else if (modelOn) begin
      if (mRunLeft > 0) begin
        mRunLeft--;
        mDone = (mRunLeft == 0);
        if (mDone) begin
          mSum  = pSum;
          mCout = pCout;
          mOvf  = pOvf;
        end
      end else begin
        mDone = 1'b0;
        if (start8) begin
          calc(a8, b8, cin8, sub8, pSum, pCout, pOvf);
          mRunLeft = W8;
          sValCnt  = 0;
        end
      end
    end
  end

  // Per-cycle comparison of the 8-bit instance against the model.
  always @(negedge clk) begin
    if (modelOn) begin
      checkOutput("busy8", busy8, mRunLeft > 0);
      checkOutput("svalid8", sValid8, mRunLeft > 0);
      checkOutput("sout8", sOut8, (mRunLeft > 0) ? pSum[W8 - mRunLeft] : 1'b0);
      checkOutput("done8", done8, mDone);
      checkOutput("sum8", sum8, mSum);
      checkOutput("cout8", cout8, mCout);
      checkOutput("ovf8", ovf8, mOvf);
      if (sValid8) sValCnt++;
      if (done8) checkOutput("svalid_count", sValCnt, W8);
    end
  end

  task automatic applyStimulus4(input logic [3:0] a, input logic [3:0] b, input logic c,
                                input logic s, input logic [3:0] expSum, input logic expC,
                                input logic expO);
    @(negedge clk); #1;
    a4 = a; b4 = b; cin4 = c; sub4 = s; start4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      checkOutput("w4_svalid", sValid4, 1'b1);
      checkOutput("w4_sout", sOut4, expSum[i]);
      checkOutput("w4_done_early", done4, 1'b0);
    end
    @(negedge clk);
    checkOutput("w4_done", done4, 1'b1);
    checkOutput("w4_busy", busy4, 1'b0);
    checkOutput("w4_sum", sum4, expSum);
    checkOutput("w4_cout", cout4, expC);
    checkOutput("w4_ovf", ovf4, expO);
    @(negedge clk);
    checkOutput("w4_done_pulse", done4, 1'b0);
  endtask

  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic s);
    @(negedge clk); #1;
    a8 = a; b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    @(negedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic waitDone8();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    if (!seen) checkOutput("done8_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] rSum;
  logic       rCo, rOv;

  initial begin
    rst = 1'b1;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy8", busy8, 1'b0);
    checkOutput("rst_done8", done8, 1'b0);
    checkOutput("rst_sum8", sum8, 8'h00);
    checkOutput("rst_sum4", sum4, 4'h0);
    checkOutput("rst_svalid4", sValid4, 1'b0);
    #1 rst = 1'b0;

    // Literal pins for the reference model
    calc(8'h05, 8'h07, 1'b0, 1'b1, rSum, rCo, rOv);
    checkOutput("model_sub_sum", rSum, 8'hFE);
    checkOutput("model_sub_cout", rCo, 1'b0);
    checkOutput("model_sub_ovf", rOv, 1'b0);
    calc(8'h7F, 8'h01, 1'b0, 1'b0, rSum, rCo, rOv);
    checkOutput("model_add_sum", rSum, 8'h80);
    checkOutput("model_add_cout", rCo, 1'b0);
    checkOutput("model_add_ovf", rOv, 1'b1);
    calc(8'h80, 8'h01, 1'b0, 1'b1, rSum, rCo, rOv);
    checkOutput("model_subovf_sum", rSum, 8'h7F);
    checkOutput("model_subovf_ovf", rOv, 1'b1);

    // 4-bit directed vectors
    applyStimulus4(4'b1101, 4'b1001, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b1);
    applyStimulus4(4'b1011, 4'b1001, 1'b1, 1'b0, 4'b0101, 1'b1, 1'b1);

    // 8-bit directed vectors
    applyStimulus8(8'h05, 8'h07, 1'b0, 1'b1);
    waitDone8();
    checkOutput("d8_sub_sum", sum8, 8'hFE);
    checkOutput("d8_sub_cout", cout8, 1'b0);
    checkOutput("d8_sub_ovf", ovf8, 1'b0);

    applyStimulus8(8'h7F, 8'h01, 1'b0, 1'b0);
    waitDone8();
    checkOutput("d8_add_sum", sum8, 8'h80);
    checkOutput("d8_add_cout", cout8, 1'b0);
    checkOutput("d8_add_ovf", ovf8, 1'b1);

    // Start while busy must be ignored
    applyStimulus8(8'h3C, 8'h15, 1'b1, 1'b0);
    @(negedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk); #1;
    start8 = 1'b0;
    waitDone8();
    checkOutput("ign_sum", sum8, 8'h52);
    checkOutput("ign_cout", cout8, 1'b0);
    checkOutput("ign_ovf", ovf8, 1'b0);

    // Start in the done cycle begins a new operation immediately
    #1;
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    checkOutput("b2b_svalid", sValid8, 1'b1);
    checkOutput("b2b_sum_held", sum8, 8'h52);
    #1 start8 = 1'b0;
    waitDone8();
    checkOutput("b2b_sum", sum8, 8'h7F);
    checkOutput("b2b_cout", cout8, 1'b1);
    checkOutput("b2b_ovf", ovf8, 1'b1);

    // Reset in the middle of an operation
    applyStimulus8(8'hAA, 8'h55, 1'b0, 1'b0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_busy", busy8, 1'b0);
    checkOutput("mrst_svalid", sValid8, 1'b0);
    checkOutput("mrst_sout", sOut8, 1'b0);
    checkOutput("mrst_done", done8, 1'b0);
    checkOutput("mrst_sum", sum8, 8'h00);
    checkOutput("mrst_cout", cout8, 1'b0);
    checkOutput("mrst_ovf", ovf8, 1'b0);
    #1 rst = 1'b0;
    applyStimulus8(8'h12, 8'h34, 1'b0, 1'b0);
    waitDone8();
    checkOutput("post_rst_sum", sum8, 8'h46);
    checkOutput("post_rst_cout", cout8, 1'b0);

    // Random sweep, both modes, with occasional ignored starts and idle gaps
    for (int n = 0; n < 1000; n++) begin
      applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk); #1;
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
        @(negedge clk); #1;
        start8 = 1'b0;
      end
      waitDone8();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
